// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp - parametrised multi-port integer register file
//
// Register 0 reads as zero and ignores writes. A clear sequencer zeroes
// registers 1..NREG-1 after reset or on request. While it runs, READY is low,
// writes are ignored and every read port returns zero. In RUN the file takes
// up to NWR writes per cycle. Port 1 wins a same-address collision. Reads
// are combinational. When BYPASS=1, a same-cycle write is forwarded to the
// read ports.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset (restarts the clear sweep)
//   i_clr_req  level request for a full clear sweep
//   o_ready    high in RUN only
//   i_we       write enable per write port             [NWR]
//   i_waddr    write addresses, port k at [k*AW +: AW]   [NWR*AW]
//   i_wdata    write data, port k at [k*XLEN +: XLEN]    [NWR*XLEN]
//   i_raddr    read addresses, port r at [r*AW +: AW]    [NRD*AW]
//   o_rdata    read data, port r at [r*XLEN +: XLEN]     [NRD*XLEN]
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr_req,
    output logic                 o_ready,
    input  logic [NWR-1:0]       i_we,
    input  logic [NWR*AW-1:0]    i_waddr,
    input  logic [NWR*XLEN-1:0]  i_wdata,
    input  logic [NRD*AW-1:0]    i_raddr,
    output logic [NRD*XLEN-1:0]  o_rdata
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_sc;
    logic               r_ready;
    logic [XLEN-1:0]    r_regs [NREG];

    logic [AW-1:0]      w_waddr [NWR];
    logic [XLEN-1:0]    w_wdata [NWR];
    logic [AW-1:0]      w_raddr [NRD];

    // Split the flat write and read buses into one entry per port.
    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wsplit
            assign w_waddr[gi] = i_waddr[gi*AW +: AW];
            assign w_wdata[gi] = i_wdata[gi*XLEN +: XLEN];
        end
        for (gi = 0; gi < NRD; gi++) begin : g_rsplit
            assign w_raddr[gi] = i_raddr[gi*AW +: AW];
        end
    endgenerate

    // Sequencer. The edge that zeroes register NREG-1 also moves the FSM to
    // RUN. A sweep therefore takes NREG-1 cycles, and READY is low for
    // exactly that long.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CLEAR;
            r_sc    <= AW'(1);
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (i_clr_req) begin
                        r_sc <= AW'(1);
                    end else if (r_sc == AW'(NREG - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_sc <= r_sc + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (i_clr_req) begin
                        r_state <= ST_CLEAR;
                        r_sc    <= AW'(1);
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_sc    <= AW'(1);
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;

    // Storage has no reset; the sweep zeroes it. Entry 0 is never written,
    // and the read path masks address 0. Write ports are applied in ascending
    // order, so port 1 overrides port 0 on a collision. A clear request seen
    // in RUN drops that cycle's writes.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_regs[r_sc] <= '0;
        end else if (!i_clr_req) begin
            for (int k = 0; k < NWR; k++) begin
                if (i_we[k] && (w_waddr[k] != '0)) begin
                    r_regs[w_waddr[k]] <= w_wdata[k];
                end
            end
        end
    end

    // Read ports. They return zero during CLEAR and for address 0. Bypass
    // checks the write ports in ascending order, so port 1 is forwarded when
    // both ports match. The nonzero-address guard keeps x0 out of bypass.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [XLEN-1:0] w_rd;
            always_comb begin
                w_rd = '0;
                if ((r_state == ST_RUN) && (w_raddr[gi] != '0)) begin
                    w_rd = r_regs[w_raddr[gi]];
                    if (BYPASS != 0) begin
                        for (int k = 0; k < NWR; k++) begin
                            if (i_we[k] && (w_waddr[k] == w_raddr[gi])) begin
                                w_rd = w_wdata[k];
                            end
                        end
                    end
                end
            end
            assign o_rdata[gi*XLEN +: XLEN] = w_rd;
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, dual-read 32x32 file.
- Adds configurable width, depth, read-port count and write-port count, plus write-to-read bypass.
- Adds a hardware clear sequencer that zeroes the array after reset or on request.
- Sits in the decode/writeback stage. Feeds operand muxes and accepts writeback from one or two retire lanes.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers. Power of two, 4..64. AW = clog2(NREG) is a local constant.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR_REQ  in  1  request a full clear sweep (level, sampled each cycle).
- READY  out  1  high when the file accepts writes and returns real data.
- WE  in  NWR  write enable per write port.
- WADDR  in  NWR*AW  write address; port k uses bits [k*AW +: AW].
- WDATA  in  NWR*XLEN  write data; port k uses bits [k*XLEN +: XLEN].
- RADDR  in  NRD*AW  read address; port r uses bits [r*AW +: AW].
- RDATA  out  NRD*XLEN  read data; port r uses bits [r*XLEN +: XLEN].

Behaviour:
- Register 0 is hardwired to zero.
  - Reads of address 0 return 0 in all states.
  - Writes to address 0 are discarded.
  - Register 0 never participates in bypass.
- FSM states:
  - CLEAR (reset state): a sweep counter SC starts at 1. Each cycle REG[SC] <= 0 and SC increments. When SC = NREG-1 is written, the FSM moves to RUN on the next edge. A sweep takes exactly NREG-1 cycles.
  - RUN: normal operation.
- RST_N low: the FSM enters CLEAR with SC=1 and READY=0 immediately (asynchronous). Array contents are not reset directly; they are zeroed by the sweep.
- READY = 1 only in RUN. It rises on the edge after the last sweep write.
- CLR_REQ sampled high:
  - in RUN, the FSM enters CLEAR with SC=1 on that edge;
  - in CLEAR, SC restarts at 1.
- In CLEAR:
  - all WE are ignored;
  - every RDATA port returns 0 regardless of address;
  - bypass is disabled.
- In RUN, writes: for each port k with WE[k]=1 and WADDR_k != 0, REG[WADDR_k] <= WDATA_k at the rising edge.
- Write collision (NWR=2, both enabled, same nonzero address): port 1 wins; port 0's data is dropped.
- A write in the same cycle that CLR_REQ is sampled in RUN is dropped; the clear takes precedence.
- Reads are combinational (zero-cycle latency), returning REG[RADDR_r].
- Bypass (BYPASS=1, RUN only): if RADDR_r matches an enabled write port's nonzero WADDR, RDATA_r = that port's WDATA. When both ports match, port 1 is forwarded.
- BYPASS=0: a read in the same cycle as a write to the same address returns the old value. The new value is visible from the next cycle.
- Out-of-range addresses (NREG not a power of two is disallowed) cannot occur.
- Reset mid-sweep or mid-RUN: restarts a full sweep; READY is low for exactly NREG-1 cycles after RST_N deasserts.

Test Plan:
- Reset with defaults: hold RST_N=0 for 3 cycles, release. READY=0 for 31 cycles then 1. All 31 registers read 0 on both ports.
- Write/read: in RUN, WE=1, WADDR=5, WDATA=0xDEADBEEF. Same cycle RADDR0=5 gives 0xDEADBEEF (BYPASS=1). Next cycle gives 0xDEADBEEF. With BYPASS=0, same cycle returns 0, next cycle 0xDEADBEEF.
- x0: write 0x12345678 to address 0. RDATA for address 0 stays 0 in that cycle and after; no bypass.
- Dual-write collision (NWR=2): port0 writes 7 <= 0xAAAA0000 and port1 writes 7 <= 0x5555FFFF in the same cycle. Same-cycle bypass and next-cycle read both give 0x5555FFFF.
- Clear request: fill r1..r31 with r_i = i. Pulse CLR_REQ with a concurrent write 3 <= 0xFFFFFFFF.
  - READY falls on the next edge; reads return 0 throughout CLEAR.
  - After 31 cycles READY=1 and r3 = 0; the write was dropped.
- Mid-sweep reset (NREG=16, NRD=4): assert RST_N=0 asynchronously at SC=9. READY stays 0 and the sweep restarts. READY rises exactly 15 cycles after release, and all 4 ports read 0 for addresses 1..15.
